seq_rca_adder: RTL
==================

Name: seq_rca_adder

Overview:
- Parametrised multi-cycle ripple-carry adder built from a chain of CHUNK full-adder cells.
- Adds two WIDTH-bit operands plus carry-in over WIDTH/CHUNK clock cycles, CHUNK bits per cycle, with a registered carry between steps.
- Trades latency for area in datapaths that do not need a single-cycle wide adder.
- Uses a start/busy/done handshake and flags unsigned carry-out and signed overflow.

Parameters:
- WIDTH, 16, operand and result width in bits; must be ≥1.
- CHUNK, 4, bits added per cycle; must divide WIDTH exactly (elaboration error otherwise).
- Derived, not a port: STEPS = WIDTH/CHUNK.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active low
- start  input  1  request a new addition; sampled only when busy=0
- a  input  WIDTH  operand A, captured on the accepting edge
- b  input  WIDTH  operand B, captured on the accepting edge
- cin  input  1  carry-in, captured on the accepting edge
- busy  output  1  high while an addition is in progress
- done  output  1  one-cycle pulse when the result becomes valid
- sum  output  WIDTH  result, (a+b+cin) mod 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1
- overflow  output  1  signed overflow: a[MSB]==b[MSB] and sum[MSB]!=a[MSB]

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n); it is sampled on the clk rising edge only.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, overflow=0, step counter=0, internal carry=0, operand registers=0.
- States:
  - IDLE: busy=0, done=0.
  - ADD: busy=1, done=0.
  - DONE: busy=0, done=1, lasts exactly one cycle.
- Acceptance: on an edge with state IDLE or DONE and start=1:
  - latch a, b, cin;
  - clear the sum register and step counter;
  - go to ADD.
- Start while busy=1 is ignored; operands are not re-sampled.
- ADD, step i = 0..STEPS-1, one per edge:
  - bits [i*CHUNK +: CHUNK] = a_chunk + b_chunk + carry_reg, through CHUNK rippled full-adder cells (sum = x^y^c, carry = majority);
  - write the chunk result into sum;
  - carry_reg ← chunk carry-out.
- After step STEPS-1:
  - cout = final carry;
  - overflow computed from latched a/b MSBs and the new sum MSB;
  - go to DONE.
- Latency: accepting edge = edge 0. Edges 1..STEPS perform the steps. After edge STEPS, done=1 and sum/cout/overflow are valid.
- Output hold: sum/cout/overflow hold their values until the next accepting edge.
- During ADD, sum bits above the current step read 0; partial results are not architecturally valid.
- DONE→IDLE on the next edge if start=0.
- Back-to-back: start=1 during DONE is accepted. done falls and busy rises on that same edge, with no idle bubble.
- rst_n=0 mid-operation: aborts the addition; all state returns to reset values on that edge. done never pulses for the aborted operation.
- rst_n=0 has priority over start on the same edge.
- CHUNK=WIDTH: STEPS=1; done asserts one cycle after acceptance.
- Changing a/b/cin while busy has no effect on the result.

Test Plan:
- Carry out of the top bit: WIDTH=16, CHUNK=4; start with a=0xFFFF, b=0x0001, cin=0 → done exactly 4 cycles after the accepting edge; sum=0x0000, cout=1, overflow=0.
- Signed overflow: a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, overflow=1. Then a=0x8000, b=0x8000 → sum=0x0000, cout=1, overflow=1.
- Carry-in and ignored start: a=0x1234, b=0x4321, cin=1 → sum=0x5556, cout=0. Pulse start with a=0xAAAA at cycle 2 of ADD → ignored; result is still 0x5556 and done pulses only once.
- Reset mid-operation and back-to-back: drive rst_n=0 at cycle 2 of ADD → next edge busy=0, done=0, sum=0, and no done pulse follows. Next, start held high through DONE with a=0x0F0F, b=0x00F1 → second operation accepted without a bubble; sum=0x1000.
- Degenerate CHUNK: WIDTH=8, CHUNK=8, a=0xC8, b=0x64, cin=0 → done 1 cycle after acceptance; sum=0x2C, cout=1, overflow=0.
- Randomised: 1000 random a/b/cin with random start gaps, WIDTH=16 and CHUNK∈{1,2,4,8,16} → every result matches the reference model a+b+cin, and the latency is always STEPS.

Source files
------------

// File: rtl/seq_rca_adder.sv
// Multi-cycle ripple-carry adder: adds WIDTH-bit operands CHUNK bits per clock
// through a short full-adder chain, carrying between steps in a register.

module rca_full_adder (
   input  logic x,
   input  logic y,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = x ^ y ^ ci;
   assign co = (x & y) | (x & ci) | (y & ci);
endmodule

module seq_rca_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);
   localparam int STEPS  = WIDTH / CHUNK;
   localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

   generate
      if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
         $error("seq_rca_adder: CHUNK must be >= 1 and divide WIDTH exactly");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADD  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t              state_reg, state_next;
   logic [WIDTH-1:0]    a_reg, a_next;
   logic [WIDTH-1:0]    b_reg, b_next;
   logic [WIDTH-1:0]    sum_reg, sum_next;
   logic [STEP_W-1:0]   step_reg, step_next;
   logic                carry_reg, carry_next;
   logic                cout_reg, cout_next;
   logic                ovf_reg, ovf_next;

   logic [31:0]         base;
   logic [CHUNK-1:0]    x_chunk;
   logic [CHUNK-1:0]    y_chunk;
   logic [CHUNK-1:0]    s_chunk;
   logic [CHUNK:0]      c_chain;

   // Slice of the latched operands handled by the current step.
   assign base    = 32'(step_reg) * 32'(CHUNK);
   assign x_chunk = a_reg[base +: CHUNK];
   assign y_chunk = b_reg[base +: CHUNK];
   assign c_chain[0] = carry_reg;

   generate
      for (genvar gi = 0; gi < CHUNK; gi++) begin : g_cell
         rca_full_adder u_fa (
            .x  (x_chunk[gi]),
            .y  (y_chunk[gi]),
            .ci (c_chain[gi]),
            .s  (s_chunk[gi]),
            .co (c_chain[gi+1])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         step_reg  <= '0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
         ovf_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         sum_reg   <= sum_next;
         step_reg  <= step_next;
         carry_reg <= carry_next;
         cout_reg  <= cout_next;
         ovf_reg   <= ovf_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      sum_next   = sum_reg;
      step_next  = step_reg;
      carry_next = carry_reg;
      cout_next  = cout_reg;
      ovf_next   = ovf_reg;
      busy       = 1'b0;
      done       = 1'b0;

      case (state_reg)
         ST_IDLE, ST_DONE: begin
            done = (state_reg == ST_DONE);
            if (start) begin
               a_next     = a;
               b_next     = b;
               carry_next = cin;
               sum_next   = '0;
               step_next  = '0;
               cout_next  = 1'b0;
               ovf_next   = 1'b0;
               state_next = ST_ADD;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_ADD: begin
            busy                     = 1'b1;
            sum_next[base +: CHUNK]  = s_chunk;
            carry_next               = c_chain[CHUNK];
            if (step_reg == LAST_STEP) begin
               // Flags use the freshly written top chunk, not the stale register.
               cout_next  = c_chain[CHUNK];
               ovf_next   = (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                            (sum_next[WIDTH-1] != a_reg[WIDTH-1]);
               state_next = ST_DONE;
            end else begin
               step_next  = step_reg + STEP_W'(1);
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign sum      = sum_reg;
   assign cout     = cout_reg;
   assign overflow = ovf_reg;

endmodule
